// File: rtl/ka_26bit_seq.sv
// Sequential 26x26 carry-less multiplier: one 13-bit Karatsuba core shared over three sub-products.
// Optional op_count output enabled by defining KA26_OP_COUNT_EN.

module ka_13bit (
  input  logic [12:0] a,
  input  logic [12:0] b,
  output logic [24:0] p
);

  function automatic logic [12:0] clmul7(input logic [6:0] x, input logic [6:0] z);
    logic [12:0] r;
    r = 13'd0;
    for (int i = 0; i < 7; i++) begin
      if (z[i]) begin
        r = r ^ ({6'd0, x} << i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [12:0] lo_s;
  logic [12:0] hi_s;
  logic [12:0] mid_s;

  // Inner Karatsuba split at bit 7: low 7 bits, high 6 bits.
  always_comb begin
    lo_s  = clmul7(a[6:0], b[6:0]);
    hi_s  = clmul7({1'b0, a[12:7]}, {1'b0, b[12:7]});
    mid_s = clmul7(a[6:0] ^ {1'b0, a[12:7]}, b[6:0] ^ {1'b0, b[12:7]});
    p     = {12'd0, lo_s} ^ ({12'd0, lo_s ^ mid_s ^ hi_s} << 5'd7) ^ ({12'd0, hi_s} << 5'd14);
  end

endmodule

module ka_26bit_seq #(
  parameter int unsigned CORE_LAT = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] a,
  input  logic [25:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [50:0] y
`ifdef KA26_OP_COUNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [25:0] a_r, a_nxt_s;
  logic [25:0] b_r, b_nxt_s;
  logic [50:0] acc_r, acc_nxt_s;
  logic [50:0] y_r, y_nxt_s;
  logic        in_ready_r, in_ready_nxt_s;
  logic        out_valid_r, out_valid_nxt_s;
  logic        wait_r, wait_nxt_s;
  logic [12:0] core_a_s;
  logic [12:0] core_b_s;
  logic [24:0] core_p_s;
  logic [24:0] prod_s;
  logic [50:0] prod_ext_s;
  logic        step_s;

  ka_13bit u_core (
    .a (core_a_s),
    .b (core_b_s),
    .p (core_p_s)
  );

  generate
    if (CORE_LAT == 32'd1) begin : g_core_reg
      logic [24:0] core_q_r;
      // Pipeline register on the core output; its contents only matter on the second MUL cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          core_q_r <= 25'd0;
        end else begin
          core_q_r <= core_p_s;
        end
      end
      assign prod_s = core_q_r;
    end else begin : g_core_comb
      assign prod_s = core_p_s;
    end
  endgenerate

  assign prod_ext_s = {26'd0, prod_s};
  assign step_s     = (CORE_LAT == 32'd0) ? 1'b1 : wait_r;

  // Core operand selection follows the current multiply phase.
  always_comb begin
    core_a_s = 13'd0;
    core_b_s = 13'd0;
    case (state_r)
      MUL0: begin
        core_a_s = a_r[12:0];
        core_b_s = b_r[12:0];
      end
      MUL1: begin
        core_a_s = a_r[25:13];
        core_b_s = b_r[25:13];
      end
      MUL2: begin
        core_a_s = a_r[12:0] ^ a_r[25:13];
        core_b_s = b_r[12:0] ^ b_r[25:13];
      end
      default: begin
        core_a_s = 13'd0;
        core_b_s = 13'd0;
      end
    endcase
  end

  // Next-state, accumulator and handshake logic.
  always_comb begin
    state_nxt_s     = state_r;
    a_nxt_s         = a_r;
    b_nxt_s         = b_r;
    acc_nxt_s       = acc_r;
    y_nxt_s         = y_r;
    in_ready_nxt_s  = in_ready_r;
    out_valid_nxt_s = out_valid_r;
    wait_nxt_s      = wait_r;
    case (state_r)
      IDLE: begin
        in_ready_nxt_s = 1'b1;
        if (in_valid && in_ready_r) begin
          a_nxt_s        = a;
          b_nxt_s        = b;
          acc_nxt_s      = 51'd0;
          wait_nxt_s     = 1'b0;
          in_ready_nxt_s = 1'b0;
          state_nxt_s    = MUL0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL0: begin
        if (step_s) begin
          acc_nxt_s   = acc_r ^ prod_ext_s ^ (prod_ext_s << 6'd13);
          wait_nxt_s  = 1'b0;
          state_nxt_s = MUL1;
        end else begin
          wait_nxt_s = 1'b1;
        end
      end
      MUL1: begin
        if (step_s) begin
          acc_nxt_s   = acc_r ^ (prod_ext_s << 6'd13) ^ (prod_ext_s << 6'd26);
          wait_nxt_s  = 1'b0;
          state_nxt_s = MUL2;
        end else begin
          wait_nxt_s = 1'b1;
        end
      end
      MUL2: begin
        if (step_s) begin
          y_nxt_s         = acc_r ^ (prod_ext_s << 6'd13);
          out_valid_nxt_s = 1'b1;
          wait_nxt_s      = 1'b0;
          state_nxt_s     = DONE;
        end else begin
          wait_nxt_s = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
          in_ready_nxt_s  = 1'b1;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        wait_nxt_s      = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= 26'd0;
      b_r         <= 26'd0;
      acc_r       <= 51'd0;
      y_r         <= 51'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      wait_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      a_r         <= a_nxt_s;
      b_r         <= b_nxt_s;
      acc_r       <= acc_nxt_s;
      y_r         <= y_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      wait_r      <= wait_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;

`ifdef KA26_OP_COUNT_EN
  logic [15:0] op_count_r;

  // Completed-handshake counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_r <= 16'd0;
    end else if (out_valid_r && out_ready) begin
      op_count_r <= op_count_r + 16'd1;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign op_count = op_count_r;
`endif

endmodule

// File: tb/tb_ka_26bit_seq.sv
// Directed self-checking bench for ka_26bit_seq (CORE_LAT=0 instance plus a CORE_LAT=1 instance).
`timescale 1ns/1ps

module tb_ka_26bit_seq;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [25:0] a, b;
  logic [50:0] y;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [25:0] a1, b1;
  logic [50:0] y1;
`ifdef KA26_OP_COUNT_EN
  logic [15:0] op_count, op_count1;
`endif

  int checks   = 0;
  int failures = 0;

  ka_26bit_seq #(.CORE_LAT(32'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef KA26_OP_COUNT_EN
    , .op_count(op_count)
`endif
  );

  ka_26bit_seq #(.CORE_LAT(32'd1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .y(y1)
`ifdef KA26_OP_COUNT_EN
    , .op_count(op_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [50:0] clmul26(input logic [25:0] x, input logic [25:0] z);
    logic [50:0] r;
    r = 51'd0;
    for (int i = 0; i < 26; i++) begin
      if (z[i]) r = r ^ ({25'd0, x} << i);
    end
    return r;
  endfunction

  // Drives one operation on the CORE_LAT=0 instance; hs selects whether to consume the result.
  task automatic run_op(input logic [25:0] av, input logic [25:0] bv, input bit hs,
                        output logic [50:0] yv, output int lat, output bit ok);
    int guard;
    ok = 1'b0; lat = 0; yv = 51'd0;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 26'h2AAAAAA; b = 26'h1555555;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    yv = y;
    ok = out_valid;
    if (hs && ok) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [50:0] yv; int lat; bit ok;
    #3;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b/%0b exp=0", out_valid, out_valid1); end
    checks++; if (y !== 51'd0) begin failures++; $display("FAIL reset_y got=%h exp=0", y); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b/%0b exp=1", in_ready, in_ready1); end
    run_op(26'h3, 26'h3, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h5) begin failures++; $display("FAIL pre_reset_op got=%h ok=%0b exp=5", yv, ok); end
    // Start another op and reset in the middle of MUL1.
    @(negedge clk); a = 26'h123; b = 26'h456; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || y !== 51'd0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset got ov=%0b y=%h ir=%0b exp 0/0/0", out_valid, y, in_ready); end
    @(negedge clk); rst = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL release_before_edge in_ready got=%0b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL release_edge got ir=%0b ov=%0b exp 1/0", in_ready, out_valid); end
    run_op(26'h1, 26'h1, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h1) begin failures++; $display("FAIL post_reset_op got=%h ok=%0b exp=1", yv, ok); end
  endtask

  task automatic test_basic();
    logic [50:0] yv; int lat; bit ok;
    run_op(26'h3, 26'h3, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h5) begin failures++; $display("FAIL basic_y got=%h exp=5", yv); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_after_hs got ov=%0b ir=%0b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_terms();
    logic [50:0] yv; int lat; bit ok;
    run_op(26'h2000, 26'h2000, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h4000000) begin failures++; $display("FAIL middle_x13sq got=%h exp=4000000", yv); end
    run_op(26'h3FFFFFF, 26'h1, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h3FFFFFF) begin failures++; $display("FAIL all_ones_times_1 got=%h exp=3ffffff", yv); end
    run_op(26'h2000000, 26'h2000000, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h4_0000_0000_0000) begin failures++; $display("FAIL high_x25sq got=%h exp=4000000000000", yv); end
    run_op(26'h155, 26'h3, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h3FF) begin failures++; $display("FAIL pattern_155x3 got=%h exp=3ff", yv); end
    run_op(26'h0, 26'h3FFFFFF, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h0) begin failures++; $display("FAIL zero_operand got=%h exp=0", yv); end
    run_op(26'h3FFFFFF, 26'h3FFFFFF, 1'b1, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h5555555555555) begin failures++; $display("FAIL all_ones_sq got=%h exp=5555555555555", yv); end
  endtask

  task automatic test_random();
    logic [50:0] yv; int lat; bit ok;
    logic [31:0] ra, rb;
    for (int k = 0; k < 200; k++) begin
      ra = $urandom; rb = $urandom;
      run_op(ra[25:0], rb[25:0], 1'b1, yv, lat, ok);
      checks++;
      if (!ok || yv !== clmul26(ra[25:0], rb[25:0])) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h got=%h exp=%h", k, ra[25:0], rb[25:0], yv, clmul26(ra[25:0], rb[25:0]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [50:0] yv; int lat; bit ok;
    run_op(26'h155, 26'h3, 1'b0, yv, lat, ok);
    checks++; if (!ok || yv !== 51'h3FF) begin failures++; $display("FAIL bp_first_y got=%h exp=3ff", yv); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); a = 26'h3FFFFFF; b = 26'h2000000;
      @(posedge clk); #1;
      checks++;
      if (y !== 51'h3FF || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d got y=%h ov=%0b ir=%0b exp 3ff/1/0", i, y, out_valid, in_ready);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got ov=%0b ir=%0b exp 0/1", out_valid, in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 51'h3FF) begin
        failures++;
        $display("FAIL bp_idle_%0d got ov=%0b ir=%0b y=%h exp 0/1/3ff", i, out_valid, in_ready, y);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back_lat1();
    logic [25:0] va [5];
    logic [25:0] vb [5];
    int lat, guard;
    va = '{26'h3, 26'h2000, 26'h2000000, 26'h3FFFFFF, 26'h155AAA};
    vb = '{26'h3, 26'h2000, 26'h2000000, 26'h1, 26'h2F0F0F};
    out_ready1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a1 = va[k]; b1 = vb[k]; in_valid1 = 1'b1;
      guard = 0;
      while (!in_ready1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat !== 6) begin failures++; $display("FAIL lat1_latency_%0d got=%0d exp=6", k, lat); end
      checks++;
      if (out_valid1 !== 1'b1 || y1 !== clmul26(va[k], vb[k])) begin
        failures++;
        $display("FAIL lat1_y_%0d got=%h exp=%h", k, y1, clmul26(va[k], vb[k]));
      end
    end
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL lat1_end got ov=%0b ir=%0b exp 0/1", out_valid1, in_ready1); end
`ifdef KA26_OP_COUNT_EN
    checks++; if (op_count1 !== 16'd5) begin failures++; $display("FAIL lat1_op_count got=%0d exp=5", op_count1); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = 26'd0; b = 26'd0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 26'd0; b1 = 26'd0;
    test_reset();
    test_basic();
    test_terms();
    test_random();
    test_backpressure();
    test_back_to_back_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ka_26bit_seq.md
Name: ka_26bit_seq

Overview:
- Sequential 26x26-bit carry-less (GF(2)[x]) polynomial multiplier.
- Time-shares one combinational 13-bit Karatsuba core (KA_13bit) across the three sub-products of a top-level Karatsuba split.
- A valid/ready FSM sequences the core and XOR-accumulates the 51-bit product.
- Sits between operand producers and wider field-reduction logic as an area-saving alternative to a fully combinational 26-bit tree.

Parameters:
- CORE_LAT, 0, extra register stages at the core output (0 or 1). Each sub-product takes CORE_LAT+1 cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  26  multiplicand polynomial, bit i = coefficient of x^i
- b  input  26  multiplier polynomial
- out_valid  output  1  y holds a completed product
- out_ready  input  1  consumer accepts y
- y  output  51  carry-less product a*b

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high. All flops clear on rst=1 regardless of clk.
  - Reset values: state=IDLE, in_ready=0, out_valid=0, y=0, operand registers=0, wait counter=0.
  - in_ready is registered and rises on the first clk edge after rst deasserts.
- Operand split: a_lo=a[12:0], a_hi=a[25:13]; same for b.
- Sub-products (each 25 bits from the core):
  - P0 = a_lo*b_lo
  - P2 = a_hi*b_hi
  - P1 = (a_lo^a_hi)*(b_lo^b_hi)
- Result: y = P0 ^ ((P0^P1^P2)<<13) ^ (P2<<26), 51 bits, bits [50:0].
  - All arithmetic is XOR. No carries, no truncation.
- FSM states: IDLE, MUL0, MUL1, MUL2, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture a and b, clear acc, set in_ready=0, go to MUL0.
  - MUL0: core inputs = a_lo, b_lo. After CORE_LAT+1 cycles, acc ^= P0 ^ (P0<<13), go to MUL1.
  - MUL1: core inputs = a_hi, b_hi. After CORE_LAT+1 cycles, acc ^= (P2<<13) ^ (P2<<26), go to MUL2.
  - MUL2: core inputs = a_lo^a_hi, b_lo^b_hi. After CORE_LAT+1 cycles, load y = acc ^ (P1<<13), set out_valid=1, go to DONE.
  - DONE: hold y and out_valid stable until out_ready=1. Then, on the same edge, out_valid=0, in_ready=1, go to IDLE.
- A wait counter (1 bit) paces each MUL state when CORE_LAT=1. The core output register is not reset-dependent for correctness.
- Latency: out_valid rises 3*(CORE_LAT+1) cycles after the accept edge (3 when CORE_LAT=0).
- Throughput: one product per 3*(CORE_LAT+1)+2 cycles with out_ready held high.
- Boundary conditions:
  - in_valid while busy is ignored; the producer must hold it.
  - a and b may change freely after accept.
  - out_ready while out_valid=0 has no effect.
  - No simultaneous accept and output: in_ready=0 in DONE.
  - rst mid-operation aborts the computation. No partial y is ever flagged valid.
  - Zero operands are legal (y=0).

Optional Feature:
- Macro: KA26_OP_COUNT_EN.
- Defined:
  - Adds output port op_count[15:0].
  - Increments by 1 on each out_valid&out_ready handshake.
  - Wraps 0xFFFF -> 0x0000.
  - Reset value 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 mid-MUL1, then release -> out_valid=0, y=0, in_ready=1 one cycle after release. The next op a=1, b=1 gives y=0x1.
- Basic, CORE_LAT=0: a=0x3, b=0x3 -> y=0x5, out_valid exactly 3 cycles after accept.
- Middle term: a=0x2000, b=0x2000 (x^13*x^13) -> y=0x4000000. Also a=0x3FFFFFF, b=0x1 -> y=0x3FFFFFF.
- High term: a=0x2000000, b=0x2000000 -> y=0x4_0000_0000_0000 (bit 50 only). Compare 200 random pairs against a bit-serial carry-less reference model.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y stable, in_ready=0, in_valid pulses ignored. Release gives exactly one handshake.
- CORE_LAT=1 with KA26_OP_COUNT_EN: 5 back-to-back ops, out_ready=1 -> each latency 6 cycles, op_count=5. Preset op_count near 0xFFFF confirms wrap to 0x0000.
